// File: rtl/fft_output_collector.sv
// FFT output collector: captures one frame of N bins delivered two per beat,
// then replays it as a natural-order serial stream over valid/ready.
module fft_output_collector #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fft_ready_i,
    input  logic [31:0]          x0_re_i,
    input  logic [31:0]          x0_im_i,
    input  logic [31:0]          x1_re_i,
    input  logic [31:0]          x1_im_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [31:0]          m_re_o,
    output logic [31:0]          m_im_o,
    output logic [$clog2(N)-1:0] m_index_o,
    output logic                 m_last_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic                 trunc_o,
    input  logic                 clear_i
);
    localparam int H  = N / 2;
    localparam int AW = $clog2(N);
    localparam int BW = $clog2(H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [63:0]     bank0_q [H];
    logic [63:0]     bank1_q [H];
    logic [63:0]     rd_data_q;
    logic [BW-1:0]   beat_q;
    logic [AW:0]     fetch_q;
    logic [AW-1:0]   rd_idx_q;
    logic            rd_valid_q;
    logic            rdy_q;
    logic            armed_q;
    logic            m_valid_q;
    logic [31:0]     m_re_q;
    logic [31:0]     m_im_q;
    logic [AW-1:0]   m_index_q;
    logic            m_last_q;
    logic            busy_q;
    logic            ovf_q;
    logic            trunc_q;

    logic            rise;
    logic            out_free;
    logic            wr_en;
    logic [BW-1:0]   wr_addr;
    logic            rd_en;
    logic            ovf_d;
    logic            trunc_d;

    // Edge detect, buffer port control and sticky flag next-state.
    // armed_q blocks a level that was already high when reset released.
    always_comb begin
        rise     = fft_ready_i & ~rdy_q & armed_q;
        out_free = ~m_valid_q | m_ready_i;
        wr_en    = 1'b0;
        wr_addr  = beat_q;
        rd_en    = 1'b0;
        if (state_q == S_IDLE) begin
            wr_en   = rise;
            wr_addr = '0;
        end else if (state_q == S_CAPTURE) begin
            wr_en   = fft_ready_i;
        end else if (state_q == S_DRAIN) begin
            rd_en   = (~rd_valid_q | out_free) & ~fetch_q[AW];
        end
        ovf_d   = (ovf_q & ~clear_i)
                | ((state_q == S_DRAIN) & rise);
        trunc_d = (trunc_q & ~clear_i)
                | ((state_q == S_CAPTURE) & ~fft_ready_i);
    end

    // Frame buffer with registered read feeding the prefetch stage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank0_q[wr_addr] <= {x0_re_i, x0_im_i};
            bank1_q[wr_addr] <= {x1_re_i, x1_im_i};
        end
        if (rd_en) begin
            rd_data_q <= fetch_q[AW-1] ? bank1_q[fetch_q[BW-1:0]]
                                       : bank0_q[fetch_q[BW-1:0]];
        end
    end

    // Control FSM: capture beats, then drain through prefetch and output regs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            fetch_q    <= '0;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
            rdy_q      <= 1'b0;
            armed_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            m_re_q     <= '0;
            m_im_q     <= '0;
            m_index_q  <= '0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            rdy_q   <= fft_ready_i;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
            if (!fft_ready_i) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        beat_q  <= BW'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (!fft_ready_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (beat_q == BW'(H - 1)) begin
                        fetch_q    <= '0;
                        rd_valid_q <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                S_DRAIN: begin
                    if (rd_en) begin
                        fetch_q    <= fetch_q + (AW+1)'(1);
                        rd_idx_q   <= fetch_q[AW-1:0];
                        rd_valid_q <= 1'b1;
                    end else if (out_free) begin
                        rd_valid_q <= 1'b0;
                    end
                    if (out_free) begin
                        m_valid_q <= rd_valid_q;
                        if (rd_valid_q) begin
                            m_re_q    <= rd_data_q[63:32];
                            m_im_q    <= rd_data_q[31:0];
                            m_index_q <= rd_idx_q;
                            m_last_q  <= (rd_idx_q == AW'(N - 1));
                        end
                    end
                    if (m_valid_q && m_ready_i && m_last_q) begin
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_valid_o  = m_valid_q;
    assign m_re_o     = m_re_q;
    assign m_im_o     = m_im_q;
    assign m_index_o  = m_index_q;
    assign m_last_o   = m_last_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign trunc_o    = trunc_q;

endmodule

// File: tb/tb_fft_output_collector.sv
// Bench for fft_output_collector: directed frames with a scoreboard queue
// of expected output words, compared on every handshake and stall.
module tb_fft_output_collector;
    localparam int N  = 8;
    localparam int H  = N / 2;
    localparam int AW = $clog2(N);

    typedef struct packed {
        logic [31:0]   re;
        logic [31:0]   im;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fft_ready_i = 1'b0;
    logic [31:0]   x0_re_i = '0;
    logic [31:0]   x0_im_i = '0;
    logic [31:0]   x1_re_i = '0;
    logic [31:0]   x1_im_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [31:0]   m_re_o;
    logic [31:0]   m_im_o;
    logic [AW-1:0] m_index_o;
    logic          m_last_o;
    logic          busy_o;
    logic          overflow_o;
    logic          trunc_o;
    logic          clear_i = 1'b0;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fft_output_collector #(.N(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fft_ready_i (fft_ready_i),
        .x0_re_i     (x0_re_i),
        .x0_im_i     (x0_im_i),
        .x1_re_i     (x1_re_i),
        .x1_im_i     (x1_im_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_re_o      (m_re_o),
        .m_im_o      (m_im_o),
        .m_index_o   (m_index_o),
        .m_last_o    (m_last_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .trunc_o     (trunc_o),
        .clear_i     (clear_i)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare the presented word against the scoreboard head, pop on
    // handshake, then advance one clock (returns at the falling edge).
    task automatic cyc();
        exp_t e;
        if (rstn && m_valid_o) begin
            if (q.size() == 0) begin
                chk("spurious_valid", m_valid_o, 0);
            end else begin
                e = q[0];
                chk("word_re", m_re_o, e.re);
                chk("word_im", m_im_o, e.im);
                chk("word_idx", m_index_o, e.idx);
                chk("word_last", m_last_o, e.last);
                if (m_ready_i) void'(q.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input int base, input int nb, input bit push);
        exp_t e;
        for (int j = 0; j < nb; j++) begin
            fft_ready_i = 1'b1;
            x0_re_i = 32'(base + j);
            x0_im_i = 32'(base + 100 + j);
            x1_re_i = 32'(base + H + j);
            x1_im_i = 32'(base + 100 + H + j);
            cyc();
            if (j == 0) chk("busy_rise", busy_o, 1);
        end
        fft_ready_i = 1'b0;
        if (push) begin
            for (int k = 0; k < N; k++) begin
                e.re   = 32'(base + k);
                e.im   = 32'(base + 100 + k);
                e.idx  = AW'(k);
                e.last = (k == N - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input bit bp);
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            m_ready_i = bp ? (n % 3 == 0) : 1'b1;
            cyc();
            n++;
        end
        chk("drain_left", q.size(), 0);
        chk("end_valid", m_valid_o, 0);
        chk("end_busy", busy_o, 0);
        m_ready_i = 1'b1;
    endtask

    task automatic check_reset();
        chk("rst_valid", m_valid_o, 0);
        chk("rst_re", m_re_o, 0);
        chk("rst_im", m_im_o, 0);
        chk("rst_idx", m_index_o, 0);
        chk("rst_last", m_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_trunc", trunc_o, 0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        cyc();
        cyc();
        check_reset();
        rstn = 1'b1;
        cyc();

        // nominal frame with latency check
        chk("idle_busy", busy_o, 0);
        send_frame(0, H, 1);
        chk("lat_e3", m_valid_o, 0);
        m_ready_i = 1'b1;
        cyc();
        chk("lat_e4", m_valid_o, 0);
        cyc();
        chk("lat_e5", m_valid_o, 1);
        wait_drain(0);

        // back-pressure
        cyc();
        send_frame(0, H, 1);
        wait_drain(1);

        // overflow: second frame arrives during a stalled drain
        m_ready_i = 1'b0;
        cyc();
        send_frame(1000, H, 1);
        n = 0;
        while (!m_valid_o && n < 20) begin
            cyc();
            n++;
        end
        chk("ovf_drain_valid", m_valid_o, 1);
        send_frame(5000, H, 0);
        chk("ovf_set", overflow_o, 1);
        wait_drain(0);
        send_frame(2000, H, 1);
        wait_drain(0);
        chk("ovf_sticky", overflow_o, 1);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        chk("ovf_clear", overflow_o, 0);

        // truncation after two beats
        send_frame(7000, 2, 0);
        cyc();
        chk("trunc_set", trunc_o, 1);
        chk("trunc_busy", busy_o, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("trunc_novalid", m_valid_o, 0);
        end
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        chk("trunc_clear", trunc_o, 0);

        // reset while index 3 is presented
        send_frame(3000, H, 1);
        m_ready_i = 1'b1;
        n = 0;
        while (!(m_valid_o && m_index_o == AW'(3)) && n < 30) begin
            cyc();
            n++;
        end
        chk("idx3_reached", m_index_o, 3);
        rstn = 1'b0;
        cyc();
        check_reset();
        q.delete();
        rstn = 1'b1;
        cyc();
        send_frame(4000, H, 1);
        wait_drain(1);

        // fft_ready_i already high when reset releases
        rstn = 1'b0;
        fft_ready_i = 1'b1;
        cyc();
        cyc();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("held_busy", busy_o, 0);
            chk("held_valid", m_valid_o, 0);
        end
        fft_ready_i = 1'b0;
        cyc();
        send_frame(6000, H, 1);
        wait_drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_output_collector.md
# fft_output_collector

Receives the result stream of the FFT chain (fft_1024 top), two complex bins per beat, buffers one full frame, and replays it as a serial natural-order stream to a downstream consumer over a valid/ready handshake. It is the consuming end of the FFT output interface. It sits directly after the final FFT architecture stage, where the FFT drives the ready, x0 and x1 outputs. It decouples the FFT's burst output from a back-pressuring consumer and flags frames it cannot accept.

## Interface
- N, 8, FFT length in points; power of two, at least 4. Buffer depth is N complex words.
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- fft_ready_i  in  1  frame-valid from the FFT; high for exactly N/2 contiguous cycles per frame
- x0_re_i, x0_im_i  in  32 each  beat j carries bin j (two's complement, passed through unmodified)
- x1_re_i, x1_im_i  in  32 each  beat j carries bin j+N/2
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  consumer accepts the word when m_valid_o and m_ready_i are both high
- m_re_o, m_im_o  out  32 each  output bin value
- m_index_o  out  $clog2(N)  bin index of the current output word
- m_last_o  out  1  high with bin N-1
- busy_o  out  1  high in CAPTURE or DRAIN
- overflow_o  out  1  sticky; frame dropped because the collector was busy
- trunc_o  out  1  sticky; fft_ready_i fell before N/2 beats
- clear_i  in  1  one-cycle pulse that clears overflow_o and trunc_o

## Operation
- Storage is two banks, each N/2 × 64 bits: bank0 holds bins 0..N/2-1 and bank1 holds bins N/2..N-1. Beat j writes x0 to bank0[j] and x1 to bank1[j].
- A registered copy of fft_ready_i (rdy_q) is used for edge detection.
- State machine:
  - IDLE: a beat with fft_ready_i=1 and rdy_q=0 (rising edge) writes beat 0, sets the beat counter to 1, and moves to CAPTURE. A high fft_ready_i with no rising edge is ignored.
  - CAPTURE: each cycle with fft_ready_i=1 writes beat counter j and increments it. After the beat with j=N/2-1 is written, move to DRAIN with the read index at 0. If fft_ready_i=0 before that beat, set trunc_o, discard the partial frame, and return to IDLE.
  - DRAIN: present bins 0..N-1 in order. Index i reads bank0[i] for i<N/2, otherwise bank1[i-N/2]. The word advances only on handshake. The handshake on i=N-1 returns the block to IDLE.
- A rising edge of fft_ready_i during DRAIN sets overflow_o. That whole frame is ignored: no writes, and the drain continues undisturbed. A new capture requires a fresh rising edge after the return to IDLE.
- clear_i clears both sticky flags. If a new set condition occurs in the same cycle as clear_i, the set wins.
- Reset in any state returns to IDLE. Buffered data is abandoned and the next frame is not expected to be aligned until a new rising edge.

## Timing
- Reset values: m_valid_o=0, m_re_o=0, m_im_o=0, m_index_o=0, m_last_o=0, busy_o=0, overflow_o=0, trunc_o=0, rdy_q=0.
- All outputs are registered.
- busy_o rises in the cycle after the first beat is sampled.
- Latency: m_valid_o rises 2 cycles after the last beat (beat N/2-1) is sampled, allowing one cycle for the synchronous buffer read and one for the output register.
- While m_valid_o=1 and m_ready_i=0, m_re_o, m_im_o, m_index_o and m_last_o hold stable. m_valid_o never drops without a handshake.
- With m_ready_i held at 1, the block sustains one word per cycle (read-ahead prefetch). A full frame drains in N cycles after the first valid.
- After the handshake on m_last_o, m_valid_o=0 and busy_o=0 in the next cycle, and the block is back in IDLE.
- Minimum frame-to-frame spacing without overflow: the next rising edge of fft_ready_i must come at least 1 cycle after busy_o falls.
- m_index_o wraps from N-1 to 0 only through IDLE, never inside a drain.

## Test plan
- Nominal frame, N=8: drive 4 contiguous beats with x0_re=j, x0_im=100+j, x1_re=4+j, x1_im=104+j, and hold m_ready_i=1. Required output: 8 words with m_re=0..7 and m_im=100..107. m_last_o is high only on index 7. First m_valid_o comes 2 cycles after beat 3.
- Back-pressure: same frame, with m_ready_i toggling 1,0,0,1,... Required: no word lost or duplicated, outputs stable during stalls, and the same sequence as the nominal case.
- Overflow: start a second 4-beat frame while draining with m_ready_i=0. Required: overflow_o=1, the first frame drains intact, and the second frame's data never appears. A third frame after busy_o falls captures normally.
- Truncation: drop fft_ready_i after 2 beats. Required: trunc_o=1, busy_o=0 one cycle later, and no m_valid_o. clear_i then returns trunc_o to 0.
- Reset mid-drain: assert rstn=0 while index 3 is presented. Required: all outputs at their reset values the next cycle. A following frame drains from index 0 with correct data.
- Held-high fft_ready_i after reset: release reset with fft_ready_i=1. Required: no capture until fft_ready_i goes low and then rises again.
